// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS-32 decode/execute slice: decode, operand extend, ALU/shift, LUI, branch/jump select.
// All outputs registered once (1-cycle latency, one instruction per cycle); reset clears outputs to a NOP.
module mips_decode_execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow,
  output logic        carry,
  output logic [4:0]  wb_reg,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [1:0]  block_size,
  output logic        lui,
  output logic        branch_taken,
  output logic        jump,
  output logic        jal,
  output logic        jr,
  output logic [12:0] target
);

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011,
    ALU_NOR  = 3'b100, ALU_SLTU = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] result;
    logic        zero, overflow, carry;
    logic [4:0]  wb_reg;
    logic        reg_write, reg_dst, mem_read, mem_write, mem_to_reg;
    logic [1:0]  block_size;
    logic        lui, branch_taken, jump, jal, jr;
    logic [12:0] target;
  } ex_t;

  logic [5:0]  opcode, funct;
  alu_op_e     alu_op;
  logic        use_imm, sext, is_shift, is_branch;
  logic        c_reg_write, c_reg_dst, c_mem_read, c_mem_write, c_mem_to_reg;
  logic        c_lui, c_jump, c_jal, c_jr;
  logic [1:0]  c_block_size;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    alu_op       = ALU_ADD;
    use_imm      = 1'b0;
    sext         = 1'b1;
    is_shift     = 1'b0;
    is_branch    = 1'b0;
    c_reg_write  = 1'b0;
    c_reg_dst    = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_block_size = 2'b00;
    c_lui        = 1'b0;
    c_jump       = 1'b0;
    c_jal        = 1'b0;
    c_jr         = 1'b0;
    case (opcode)
      6'b000000: begin
        c_reg_write = 1'b1;
        c_reg_dst   = 1'b1;
        case (funct)
          6'b100000, 6'b100001: alu_op = ALU_ADD;
          6'b100010, 6'b100011: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b100110: alu_op = ALU_XOR;
          6'b100111: alu_op = ALU_NOR;
          6'b101010: alu_op = ALU_SLT;
          6'b101011: alu_op = ALU_SLTU;
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111: is_shift = 1'b1;
          6'b001000: begin
            c_reg_write = 1'b0;
            c_reg_dst   = 1'b0;
            c_jump      = 1'b1;
            c_jr        = 1'b1;
          end
          default: begin
            c_reg_write = 1'b0;
            c_reg_dst   = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001: begin use_imm = 1'b1; c_reg_write = 1'b1; end
      6'b001010: begin alu_op = ALU_SLT;  use_imm = 1'b1; c_reg_write = 1'b1; end
      6'b001011: begin alu_op = ALU_SLTU; use_imm = 1'b1; c_reg_write = 1'b1; end
      6'b001100: begin alu_op = ALU_AND; use_imm = 1'b1; sext = 1'b0; c_reg_write = 1'b1; end
      6'b001101: begin alu_op = ALU_OR;  use_imm = 1'b1; sext = 1'b0; c_reg_write = 1'b1; end
      6'b001110: begin alu_op = ALU_XOR; use_imm = 1'b1; sext = 1'b0; c_reg_write = 1'b1; end
      6'b001111: begin c_lui = 1'b1; c_block_size = 2'b10; c_reg_write = 1'b1; end
      6'b100011, 6'b100001, 6'b100000: begin
        use_imm      = 1'b1;
        c_mem_read   = 1'b1;
        c_mem_to_reg = 1'b1;
        c_reg_write  = 1'b1;
        c_block_size = (opcode[1:0] == 2'b11) ? 2'b00 : (opcode[0] ? 2'b01 : 2'b11);
      end
      6'b101011, 6'b101001, 6'b101000: begin
        use_imm      = 1'b1;
        c_mem_write  = 1'b1;
        c_block_size = (opcode[1:0] == 2'b11) ? 2'b00 : (opcode[0] ? 2'b01 : 2'b11);
      end
      6'b000100, 6'b000101: begin alu_op = ALU_SUB; is_branch = 1'b1; end
      6'b000010: c_jump = 1'b1;
      6'b000011: begin c_jump = 1'b1; c_jal = 1'b1; c_reg_write = 1'b1; end
      default: ;
    endcase
  end

  logic [31:0] op_b, b_eff, alu_res, sh_res, res;
  logic [32:0] sum;
  logic [4:0]  sh_amt;
  logic        is_sub, is_addsub, res_zero;

  assign op_b      = use_imm ? (sext ? {{16{instr[15]}}, instr[15:0]} : {16'h0, instr[15:0]}) : rt_data;
  assign is_sub    = (alu_op == ALU_SUB);
  assign b_eff     = is_sub ? ~op_b : op_b;
  // SUB is A + ~B + 1, so carry-out high means no borrow.
  assign sum       = {1'b0, rs_data} + {1'b0, b_eff} + {32'h0, is_sub};
  assign is_addsub = !is_shift && !c_lui && (alu_op == ALU_ADD || is_sub);
  assign sh_amt    = funct[2] ? rs_data[4:0] : instr[10:6];

  always_comb begin
    sh_res = rt_data << sh_amt;
    if (funct[1]) sh_res = funct[0] ? 32'($signed(rt_data) >>> sh_amt) : (rt_data >> sh_amt);
  end

  always_comb begin
    case (alu_op)
      ALU_AND:  alu_res = rs_data & op_b;
      ALU_OR:   alu_res = rs_data | op_b;
      ALU_XOR:  alu_res = rs_data ^ op_b;
      ALU_NOR:  alu_res = ~(rs_data | op_b);
      ALU_SLTU: alu_res = {31'h0, rs_data < op_b};
      ALU_SLT:  alu_res = {31'h0, $signed(rs_data) < $signed(op_b)};
      default:  alu_res = sum[31:0];
    endcase
  end

  assign res      = c_lui ? {instr[15:0], 16'h0} : (is_shift ? sh_res : alu_res);
  assign res_zero = (res == 32'h0);

  ex_t ex_d, ex_q;

  always_comb begin
    ex_d              = '0;
    ex_d.result       = res;
    ex_d.zero         = res_zero;
    ex_d.carry        = is_addsub & sum[32];
    ex_d.overflow     = is_addsub & (rs_data[31] == b_eff[31]) & (sum[31] != rs_data[31]);
    ex_d.wb_reg       = c_reg_dst ? instr[15:11] : (c_jal ? 5'd31 : instr[20:16]);
    ex_d.reg_write    = c_reg_write;
    ex_d.reg_dst      = c_reg_dst;
    ex_d.mem_read     = c_mem_read;
    ex_d.mem_write    = c_mem_write;
    ex_d.mem_to_reg   = c_mem_to_reg;
    ex_d.block_size   = c_block_size;
    ex_d.lui          = c_lui;
    ex_d.branch_taken = is_branch & (res_zero ^ opcode[0]);
    ex_d.jump         = c_jump;
    ex_d.jal          = c_jal;
    ex_d.jr           = c_jr;
    ex_d.target       = instr[12:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign alu_result   = ex_q.result;
  assign zero         = ex_q.zero;
  assign overflow     = ex_q.overflow;
  assign carry        = ex_q.carry;
  assign wb_reg       = ex_q.wb_reg;
  assign reg_write    = ex_q.reg_write;
  assign reg_dst      = ex_q.reg_dst;
  assign mem_read     = ex_q.mem_read;
  assign mem_write    = ex_q.mem_write;
  assign mem_to_reg   = ex_q.mem_to_reg;
  assign block_size   = ex_q.block_size;
  assign lui          = ex_q.lui;
  assign branch_taken = ex_q.branch_taken;
  assign jump         = ex_q.jump;
  assign jal          = ex_q.jal;
  assign jr           = ex_q.jr;
  assign target       = ex_q.target;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Bench for mips_decode_execute: directed vector table, reset sequence, random vs reference model.
module tb_mips_decode_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, rs_data, rt_data;
  logic [31:0] alu_result;
  logic        zero, overflow, carry;
  logic [4:0]  wb_reg;
  logic        reg_write, reg_dst, mem_read, mem_write, mem_to_reg;
  logic [1:0]  block_size;
  logic        lui, branch_taken, jump, jal, jr;
  logic [12:0] target;

  int nvec = 0;
  int nmis = 0;

  mips_decode_execute dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_result(alu_result), .zero(zero), .overflow(overflow), .carry(carry),
    .wb_reg(wb_reg), .reg_write(reg_write), .reg_dst(reg_dst), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .block_size(block_size), .lui(lui),
    .branch_taken(branch_taken), .jump(jump), .jal(jal), .jr(jr), .target(target)
  );

  always #5 clk = ~clk;

  // ctrl = {reg_dst, mem_read, mem_write, mem_to_reg, block_size[1:0], lui, branch_taken, jump, jal, jr}
  typedef struct packed {
    logic [31:0] res;
    logic        z, v, c, rw;
    logic [4:0]  wb;
    logic [10:0] ctrl;
    logic [12:0] tgt;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] instr, rs, rt, res;
    logic        z, v, c;
    bit          chk_alu, chk_c;
    logic        rw;
    logic [4:0]  wb;
    logic [10:0] ctrl;
  } vec_t;

  function automatic outs_t dut_out();
    outs_t o;
    o.res  = alu_result;
    o.z    = zero;
    o.v    = overflow;
    o.c    = carry;
    o.rw   = reg_write;
    o.wb   = wb_reg;
    o.ctrl = {reg_dst, mem_read, mem_write, mem_to_reg, block_size, lui, branch_taken, jump, jal, jr};
    o.tgt  = target;
    return o;
  endfunction

  // Reference model: kinds 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 sltu,8 shift,9 lui.
  function automatic outs_t model(input logic [31:0] i, a, b, output bit arith);
    outs_t o;
    logic [5:0]  op = i[31:26];
    logic [5:0]  fn = i[5:0];
    logic [31:0] simm = {{16{i[15]}}, i[15:0]};
    logic [31:0] opb = b;
    logic [31:0] r;
    logic [4:0]  amt;
    int          kind = 0;
    logic rw = 0, rdst = 0, mr = 0, mw = 0, mtr = 0, br = 0, j = 0, jl = 0, jrr = 0, lu = 0;
    logic [1:0]  bs = 2'b00;
    longint      sres;
    if (op == 6'd0) begin
      rw = 1; rdst = 1;
      case (fn)
        6'h20, 6'h21: kind = 0;
        6'h22, 6'h23: kind = 1;
        6'h24: kind = 2;
        6'h25: kind = 3;
        6'h26: kind = 4;
        6'h27: kind = 5;
        6'h2A: kind = 6;
        6'h2B: kind = 7;
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: kind = 8;
        6'h08: begin rw = 0; rdst = 0; j = 1; jrr = 1; end
        default: begin rw = 0; rdst = 0; end
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin kind = 0; opb = simm; rw = 1; end
        6'h0A: begin kind = 6; opb = simm; rw = 1; end
        6'h0B: begin kind = 7; opb = simm; rw = 1; end
        6'h0C: begin kind = 2; opb = {16'h0, i[15:0]}; rw = 1; end
        6'h0D: begin kind = 3; opb = {16'h0, i[15:0]}; rw = 1; end
        6'h0E: begin kind = 4; opb = {16'h0, i[15:0]}; rw = 1; end
        6'h0F: begin kind = 9; lu = 1; bs = 2'b10; rw = 1; end
        6'h23: begin opb = simm; mr = 1; mtr = 1; rw = 1; bs = 2'b00; end
        6'h21: begin opb = simm; mr = 1; mtr = 1; rw = 1; bs = 2'b01; end
        6'h20: begin opb = simm; mr = 1; mtr = 1; rw = 1; bs = 2'b11; end
        6'h2B: begin opb = simm; mw = 1; bs = 2'b00; end
        6'h29: begin opb = simm; mw = 1; bs = 2'b01; end
        6'h28: begin opb = simm; mw = 1; bs = 2'b11; end
        6'h04, 6'h05: begin kind = 1; br = 1; end
        6'h02: j = 1;
        6'h03: begin j = 1; jl = 1; rw = 1; end
        default: ;
      endcase
    end
    o = '0;
    arith = (kind <= 1);
    case (kind)
      0: begin
        r    = a + opb;
        o.c  = ({32'h0, a} + {32'h0, opb}) > 64'hFFFF_FFFF;
        sres = longint'($signed(a)) + longint'($signed(opb));
        o.v  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      1: begin
        r    = a - opb;
        o.c  = (a >= opb);
        sres = longint'($signed(a)) - longint'($signed(opb));
        o.v  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      2: r = a & opb;
      3: r = a | opb;
      4: r = a ^ opb;
      5: r = ~(a | opb);
      6: r = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
      7: r = (a < opb) ? 32'd1 : 32'd0;
      8: begin
        amt = fn[2] ? a[4:0] : i[10:6];
        if (fn[1:0] == 2'b00)      r = b << amt;
        else if (fn[1:0] == 2'b10) r = b >> amt;
        else                       r = $signed(b) >>> amt;
      end
      default: r = {i[15:0], 16'h0};
    endcase
    o.res  = r;
    o.z    = (r == 32'h0);
    o.rw   = rw;
    o.wb   = rdst ? i[15:11] : (jl ? 5'd31 : i[20:16]);
    o.ctrl = {rdst, mr, mw, mtr, bs, lu, br & (o.z ^ op[0]), j, jl, jrr};
    o.tgt  = i[12:0];
    return o;
  endfunction

  task automatic apply(input logic [31:0] i, a, b);
    @(negedge clk);
    instr = i; rs_data = a; rt_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_full(input string name, input outs_t exp, input bit chk_c);
    outs_t act = dut_out();
    outs_t a2 = act;
    outs_t e2 = exp;
    if (!chk_c) begin a2.c = 1'b0; e2.c = 1'b0; end
    nvec++;
    if (a2 !== e2) begin
      nmis++;
      $display("FAIL %s: got %h want %h (instr %h rs %h rt %h)", name, act, exp, instr, rs_data, rt_data);
    end
  endtask

  vec_t vecs[$];

  initial begin
    outs_t exp, act;
    bit    ar, bad;
    logic [5:0]  ops[22] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    logic [5:0]  fns[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                             6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3F};
    logic [31:0] edges[6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h5};

    //          name     instr          rs             rt             res            z  v  c  alu c  rw wb     ctrl
    vecs.push_back(vec_t'{"add",  32'h00221820, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 0, 1, 0, 1, 1, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"beq",  32'h10220010, 32'h5,         32'h5,        32'h0,         1, 0, 1, 1, 1, 0, 5'd2,  11'h008});
    vecs.push_back(vec_t'{"bne",  32'h14220010, 32'h5,         32'h5,        32'h0,         1, 0, 1, 1, 1, 0, 5'd2,  11'h000});
    vecs.push_back(vec_t'{"sra",  32'h00021903, 32'h0,         32'h8000_0000, 32'hF800_0000, 0, 0, 0, 1, 0, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"srl",  32'h00021902, 32'h0,         32'h8000_0000, 32'h0800_0000, 0, 0, 0, 1, 0, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"sllv", 32'h00221804, 32'd33,        32'h8000_0000, 32'h0,         1, 0, 0, 1, 0, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"lui",  32'h3C021234, 32'h0,         32'h0,        32'h1234_0000, 0, 0, 0, 1, 0, 1, 5'd2,  11'h050});
    vecs.push_back(vec_t'{"andi", 32'h30228000, 32'hFFFF_FFFF, 32'h0,        32'h0000_8000, 0, 0, 0, 1, 0, 1, 5'd2,  11'h000});
    vecs.push_back(vec_t'{"addi", 32'h2022FFFF, 32'h1,         32'h0,        32'h0,         1, 0, 1, 1, 1, 1, 5'd2,  11'h000});
    vecs.push_back(vec_t'{"sb",   32'hA022FFFC, 32'h100,       32'h0,        32'hFC,        0, 0, 1, 1, 1, 0, 5'd2,  11'h160});
    vecs.push_back(vec_t'{"lh",   32'h84220004, 32'h10,        32'h0,        32'h14,        0, 0, 0, 1, 1, 1, 5'd2,  11'h2A0});
    vecs.push_back(vec_t'{"jal",  32'h0C000123, 32'h0,         32'h0,        32'h0,         0, 0, 0, 0, 0, 1, 5'd31, 11'h006});
    vecs.push_back(vec_t'{"jr",   32'h03E00008, 32'h0,         32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 5'd0,  11'h005});
    vecs.push_back(vec_t'{"undef", 32'hFC221234, 32'h3,        32'h4,        32'h7,         0, 0, 0, 1, 1, 0, 5'd2,  11'h000});
    vecs.push_back(vec_t'{"subov", 32'h00221822, 32'h8000_0000, 32'h1,       32'h7FFF_FFFF, 0, 1, 1, 1, 1, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"slt",  32'h0022182A, 32'hFFFF_FFFF, 32'h1,        32'h1,         0, 0, 0, 1, 0, 1, 5'd3,  11'h400});
    vecs.push_back(vec_t'{"sltu", 32'h0022182B, 32'hFFFF_FFFF, 32'h1,        32'h0,         1, 0, 0, 1, 0, 1, 5'd3,  11'h400});

    rst_n = 1'b0; instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    #1;
    check_full("reset_state", '0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      apply(vecs[k].instr, vecs[k].rs, vecs[k].rt);
      act = dut_out();
      bad = (act.rw !== vecs[k].rw) || (act.wb !== vecs[k].wb) || (act.ctrl !== vecs[k].ctrl) ||
            (act.tgt !== vecs[k].instr[12:0]);
      if (vecs[k].chk_alu)
        bad |= (act.res !== vecs[k].res) || (act.z !== vecs[k].z) || (act.v !== vecs[k].v);
      if (vecs[k].chk_c) bad |= (act.c !== vecs[k].c);
      nvec++;
      if (bad) begin
        nmis++;
        $display("FAIL %s: got res=%h z=%b v=%b c=%b rw=%b wb=%0d ctrl=%h want res=%h z=%b v=%b c=%b rw=%b wb=%0d ctrl=%h",
                 vecs[k].name, act.res, act.z, act.v, act.c, act.rw, act.wb, act.ctrl,
                 vecs[k].res, vecs[k].z, vecs[k].v, vecs[k].c, vecs[k].rw, vecs[k].wb, vecs[k].ctrl);
      end
    end

    // Asynchronous reset mid-cycle after a registered add, then release and recapture.
    apply(32'h00221820, 32'h7FFF_FFFF, 32'h1);
    exp = model(32'h00221820, 32'h7FFF_FFFF, 32'h1, ar);
    check_full("pre_reset_add", exp, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_full("async_reset_clear", '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    check_full("held_until_edge", '0, 1'b1);
    @(posedge clk);
    #1;
    check_full("post_reset_capture", exp, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] i, a, b;
      i = $urandom;
      i[31:26] = ops[$urandom_range(21, 0)];
      if (i[31:26] == 6'h00) i[5:0] = fns[$urandom_range(17, 0)];
      if ($urandom_range(3, 0) == 0) i[31:26] = 6'($urandom);
      a = ($urandom_range(2, 0) == 0) ? edges[$urandom_range(5, 0)] : $urandom;
      b = ($urandom_range(2, 0) == 0) ? edges[$urandom_range(5, 0)] : $urandom;
      if ($urandom_range(4, 0) == 0) b = a;
      apply(i, a, b);
      exp = model(i, a, b, ar);
      check_full("random", exp, ar);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mips_decode_execute.md
# mips_decode_execute

Single-cycle MIPS-32 decode/execute slice: decodes a 32-bit instruction into datapath control signals, performs the ALU or shift operation on the two register operands (or an extended immediate), forms the LUI value, and resolves branch/jump selection. It sits between the register file read and the memory/writeback stages of the `mips32` core. All outputs are registered once.

## Interface
- Parameters: none; datapath fixed at 32 bits, register index 5 bits.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction word.
- `rs_data` in 32: register file read port 1 (`instr[25:21]`).
- `rt_data` in 32: register file read port 2 (`instr[20:16]`).
- `alu_result` out 32: ALU/shift result, or LUI value when `lui`.
- `zero`, `overflow`, `carry` out 1 each: ALU flags.
- `wb_reg` out 5: `rd` if `reg_dst`, 31 if `jal`, else `rt`.
- `reg_write`, `reg_dst`, `mem_read`, `mem_write`, `mem_to_reg` out 1 each.
- `block_size` out 2: 00 word, 01 half, 11 byte, 10 LUI.
- `lui` out 1: `block_size == 2'b10`.
- `branch_taken`, `jump`, `jal`, `jr` out 1 each: next-PC selection.
- `target` out 13: `instr[12:0]` (jump target or branch offset).

## Operation
- ALU codes: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT.
- Operand B: `rt_data`, or the 32-bit extended `instr[15:0]` for I-type. Sign-extend for arithmetic, compare, load, store and branch; zero-extend for `andi`, `ori`, `xori`.
- R-type (opcode 000000), by funct:
  - 100000/100001 add/addu; 100010/100011 sub/subu.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt, 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra; 000100/000110/000111 sllv/srlv/srav.
  - 001000 jr.
  - R-type ALU ops: `reg_write=1`, `reg_dst=1`.
- Shifts: operand is `rt_data`.
  - Amount: `rs_data[4:0]` if funct[2], else `instr[10:6]`.
  - Direction: funct[1]=0 left, 1 right; funct[0]=1 arithmetic right.
  - Shift by 0 passes the operand through.
- I-type, by opcode, all `reg_write=1`:
  - 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu.
  - 001100 andi, 001101 ori, 001110 xori.
  - 001111 lui: result `{instr[15:0],16'h0}`, `block_size=10`.
- Loads 100011 lw, 100001 lh, 100000 lb:
  - ADD `rs_data` + simm; `mem_read`, `mem_to_reg`, `reg_write`.
  - `block_size` 00/01/11.
- Stores 101011 sw, 101001 sh, 101000 sb:
  - ADD `rs_data` + simm; `mem_write`.
  - `block_size` 00/01/11.
- Branches 000100 beq, 000101 bne: SUB `rs_data`-`rt_data`; `branch_taken = zero XOR opcode[0]`.
- Jumps:
  - 000010 j: `jump=1`.
  - 000011 jal: `jump=jal=reg_write=1`, `wb_reg=31`.
  - jr: `jump=jr=1`, no register write.
- Flags:
  - `zero` = (result == 0).
  - `carry` = adder carry-out; SUB uses `A + ~B + 1`, so carry=1 means no borrow.
  - `overflow` = signed overflow of ADD/SUB; 0 for all other ops.
  - Flags are never gated; software decides whether to trap.
- Undefined opcode/funct: all control outputs 0, ALU performs ADD with B=`rt_data`; acts as NOP.

## Timing
- Decode, extend, ALU and branch resolution are combinational from `instr`/`rs_data`/`rt_data`.
- Every output is registered on `clk` rising edge. Latency is exactly 1 cycle, with a new instruction accepted every cycle; no handshake.
- `rst_n` low asynchronously clears every output to 0 (a NOP), including mid-operation. The first capture occurs on the first rising edge after `rst_n` deasserts.

## Test plan
- add: `rs=0x7FFFFFFF`, `rt=1`, funct 100000 -> next edge `alu_result=0x80000000`, `overflow=1`, `carry=0`, `reg_write=1`, `wb_reg=rd`.
- sub/beq:
  - `rs=rt=5`, opcode 000100 -> `zero=1`, `branch_taken=1`, `carry=1`.
  - Same operands, opcode 000101 -> `branch_taken=0`.
- Shifts, `rt=0x80000000`:
  - sra shamt 4 -> `0xF8000000`.
  - srl -> `0x08000000`.
  - sllv with `rs=33` -> shift by 1 -> `0x00000000`, `zero=1`.
- Immediates:
  - lui `imm=0x1234` -> `alu_result=0x12340000`, `lui=1`.
  - andi `imm=0x8000`, `rs=0xFFFFFFFF` -> `0x00008000` (zero-extended).
  - addi `imm=0xFFFF`, `rs=1` -> `0`.
- Memory/jumps:
  - sb with `rs=0x100`, `imm=-4` -> `alu_result=0xFC`, `mem_write=1`, `block_size=11`.
  - jal -> `jump=jal=reg_write=1`, `wb_reg=31`.
  - jr -> `jr=1`, `reg_write=0`.
- Reset: assert `rst_n=0` between clock edges after a registered add -> all outputs 0 immediately. Release -> next edge captures the current instruction.
